// File: rtl/dilation_stream.sv
// Streaming 3x3 binary dilation: per-bit OR over a K-masked window, with its own two line buffers.
// Latency: out_read pulses exactly 2 clocks after the qualifying in_write; (W-2)x(H-2) results per frame.
// No backpressure: fixed pipeline, in_write may have arbitrary gaps. Optional out_eof via DILATION_STREAM_EOF_EN.
module dilation_stream #(
   parameter int         N         = 1,
   parameter int         MAX_WIDTH = 1024,
   parameter logic [8:0] K         = 9'h1FF
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [15:0]   width,
   input  logic [15:0]   height,
   input  logic          in_write,
   input  logic [N-1:0]  in_pixel,
   output logic          out_read,
`ifdef DILATION_STREAM_EOF_EN
   output logic          out_eof,
`endif
   output logic [N-1:0]  out_pixel
);

   localparam int          AW      = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [16:0] MAX_W17 = 17'(MAX_WIDTH);

   // frame position and per-frame parameters
   logic [15:0] col_q, col_d;
   logic [15:0] row_q, row_d;
   logic [15:0] width_q, width_d;
   logic [15:0] height_q, height_d;
   logic        frame_ok_q, frame_ok_d;

   // effective parameters for the pixel being written this cycle
   logic        first_px;
   logic [15:0] cur_w;
   logic [15:0] cur_h;
   logic        cur_ok;
   logic        last_col;
   logic        last_row;

   // stage 1: pixel accepted, line-buffer read data arriving
   logic          vld1_q, vld1_d;
   logic          qual1_q, qual1_d;
   logic [AW-1:0] addr1_q, addr1_d;
   logic [N-1:0]  pix1_q, pix1_d;
   logic [N-1:0]  lb0_rd_q;
   logic [N-1:0]  lb1_rd_q;

   // line buffers: lb1 holds row-1, lb0 holds row-2
   logic [N-1:0] lb0_mem [MAX_WIDTH];
   logic [N-1:0] lb1_mem [MAX_WIDTH];

   // 3x3 window, element 3*r+c, r=0 oldest row, c=0 oldest column
   logic [N-1:0] win_q [9];
   logic [N-1:0] win_d [9];
   logic [N-1:0] dil;

   // output stage
   logic         out_read_q, out_read_d;
   logic [N-1:0] out_pixel_q, out_pixel_d;

   // Counter advance; width/height/frame_ok are latched on pixel (0,0) and held for the frame
   always_comb begin
      first_px   = (col_q == 16'd0) && (row_q == 16'd0);
      cur_w      = first_px ? width  : width_q;
      cur_h      = first_px ? height : height_q;
      cur_ok     = first_px ? (({1'b0, width} <= MAX_W17) && (width >= 16'd3) && (height >= 16'd3))
                            : frame_ok_q;
      last_col   = (col_q == cur_w - 16'd1);
      last_row   = (row_q == cur_h - 16'd1);
      col_d      = col_q;
      row_d      = row_q;
      width_d    = width_q;
      height_d   = height_q;
      frame_ok_d = frame_ok_q;
      if (in_write) begin
         width_d    = cur_w;
         height_d   = cur_h;
         frame_ok_d = cur_ok;
         if (last_col) begin
            col_d = 16'd0;
            row_d = last_row ? 16'd0 : row_q + 16'd1;
         end else begin
            col_d = col_q + 16'd1;
         end
      end
      vld1_d  = in_write;
      qual1_d = in_write && cur_ok && (row_q >= 16'd2) && (col_q >= 16'd2);
      addr1_d = col_q[AW-1:0];
      pix1_d  = in_pixel;
   end

   // Line buffers: read on in_write, write-back one cycle later once the read data is in hand.
   // A later-row access to the same column is at least 3 cycles away, so no forwarding is needed.
   always_ff @(posedge clock) begin
      if (in_write) begin
         lb0_rd_q <= lb0_mem[col_q[AW-1:0]];
         lb1_rd_q <= lb1_mem[col_q[AW-1:0]];
      end
      if (vld1_q) begin
         lb0_mem[addr1_q] <= lb1_rd_q;
         lb1_mem[addr1_q] <= pix1_q;
      end
   end

   // Window shift with the new column {lb0, lb1, pixel}, then masked OR of the shifted window
   always_comb begin
      win_d = win_q;
      if (vld1_q) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = lb0_rd_q;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = lb1_rd_q;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = pix1_q;
      end
      dil = '0;
      for (int i = 0; i < 9; i++) begin
         if (K[i]) dil = dil | win_d[i];
      end
      out_read_d  = vld1_q && qual1_q;
      out_pixel_d = out_read_d ? dil : '0;
   end

   // State registers; reset also discards any in-flight result
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q       <= '0;
         row_q       <= '0;
         width_q     <= '0;
         height_q    <= '0;
         frame_ok_q  <= 1'b0;
         vld1_q      <= 1'b0;
         qual1_q     <= 1'b0;
         addr1_q     <= '0;
         pix1_q      <= '0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
         out_read_q  <= 1'b0;
         out_pixel_q <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         width_q     <= width_d;
         height_q    <= height_d;
         frame_ok_q  <= frame_ok_d;
         vld1_q      <= vld1_d;
         qual1_q     <= qual1_d;
         addr1_q     <= addr1_d;
         pix1_q      <= pix1_d;
         win_q       <= win_d;
         out_read_q  <= out_read_d;
         out_pixel_q <= out_pixel_d;
      end
   end

   assign out_read  = out_read_q;
   assign out_pixel = out_pixel_q;

`ifdef DILATION_STREAM_EOF_EN
   logic eof1_q, eof1_d;
   logic out_eof_q, out_eof_d;

   // Last result of a frame is the one whose input is the bottom-right pixel
   always_comb begin
      eof1_d    = qual1_d && last_col && last_row;
      out_eof_d = vld1_q && eof1_q;
   end

   // End-of-frame flag follows the same two-stage path as out_read
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         eof1_q    <= 1'b0;
         out_eof_q <= 1'b0;
      end else begin
         eof1_q    <= eof1_d;
         out_eof_q <= out_eof_d;
      end
   end

   assign out_eof = out_eof_q;
`endif

endmodule
